companion_action_player: RTL and testbench

//  Executor end of the companion_interface exec/exec_status handshake: latches the selected

---
 rtl/companion_action_player.sv | 127 ++++++++++++
 tb/tb_companion_action_player.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/companion_action_player.sv
// Executor side of the exec/exec_status handshake: latches a care action on an exec rising edge and plays its animation frame by frame.
// Optional macro COMPANION_ABORT_EN: an exec falling edge during playback aborts the animation.
module companion_action_player #(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int FRAME_RATE   = 10,
  parameter int FEED_FRAMES  = 8,
  parameter int PLAY_FRAMES  = 8,
  parameter int CLEAN_FRAMES = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exec,
  input  logic [1:0] selected,
  output logic       exec_status,
  output logic       anim_active,
  output logic [1:0] anim_action,
  output logic [4:0] frame_index,
  output logic [6:0] sprite_addr,
  output logic       frame_strobe
);

  localparam int TICKS_DIV = CLOCK_FREQ / FRAME_RATE;
  localparam int TICKS     = (TICKS_DIV < 1) ? 1 : TICKS_DIV;
  localparam int TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t          r_state;
  logic            r_exec_q;
  logic [TW-1:0]   r_timer;
  logic            r_exec_status;
  logic            r_anim_active;
  logic [1:0]      r_anim_action;
  logic [4:0]      r_frame_index;
  logic            r_frame_strobe;

  logic            w_start;
  logic [4:0]      w_last;

  assign w_start = exec & ~r_exec_q;

`ifdef COMPANION_ABORT_EN
  logic            w_fall;
  assign w_fall = ~exec & r_exec_q;
`endif

  // Index of the final frame for the action currently being played.
  always_comb begin
    w_last = 5'd0;
    case (r_anim_action)
      2'b01:   w_last = 5'(FEED_FRAMES - 1);
      2'b10:   w_last = 5'(PLAY_FRAMES - 1);
      2'b11:   w_last = 5'(CLEAN_FRAMES - 1);
      default: w_last = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_exec_q       <= 1'b1;
      r_timer        <= '0;
      r_exec_status  <= 1'b1;
      r_anim_active  <= 1'b0;
      r_anim_action  <= 2'b00;
      r_frame_index  <= 5'd0;
      r_frame_strobe <= 1'b0;
    end else begin
      r_exec_q       <= exec;
      r_frame_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start && (selected != 2'b00)) begin
            r_state        <= S_RUN;
            r_anim_action  <= selected;
            r_frame_index  <= 5'd0;
            r_timer        <= '0;
            r_exec_status  <= 1'b0;
            r_anim_active  <= 1'b1;
            r_frame_strobe <= 1'b1;
          end
        end
        S_RUN: begin
`ifdef COMPANION_ABORT_EN
          if (w_fall) begin
            r_state       <= S_IDLE;
            r_exec_status <= 1'b1;
            r_anim_active <= 1'b0;
            r_anim_action <= 2'b00;
            r_frame_index <= 5'd0;
            r_timer       <= '0;
          end else
`endif
          if (r_timer == TICK_LAST) begin
            r_timer <= '0;
            if (r_frame_index < w_last) begin
              r_frame_index  <= r_frame_index + 5'd1;
              r_frame_strobe <= 1'b1;
            end else begin
              // Last frame has had its full duration; hand the handshake back.
              r_state       <= S_IDLE;
              r_exec_status <= 1'b1;
              r_anim_active <= 1'b0;
              r_anim_action <= 2'b00;
              r_frame_index <= 5'd0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exec_status  = r_exec_status;
  assign anim_active  = r_anim_active;
  assign anim_action  = r_anim_action;
  assign frame_index  = r_frame_index;
  assign frame_strobe = r_frame_strobe;
  assign sprite_addr  = {r_anim_action, r_frame_index};

endmodule

// File: tb/tb_companion_action_player.sv
// Bench for companion_action_player with TICKS=4: directed scenarios plus a random phase,
// every cycle compared against a start-time/arithmetic reference model.
module tb_companion_action_player;

  localparam int TICKS = 4;
`ifdef COMPANION_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       exec;
  logic [1:0] selected;
  logic       exec_status;
  logic       anim_active;
  logic [1:0] anim_action;
  logic [4:0] frame_index;
  logic [6:0] sprite_addr;
  logic       frame_strobe;

  companion_action_player #(
    .CLOCK_FREQ  (4),
    .FRAME_RATE  (1),
    .FEED_FRAMES (8),
    .PLAY_FRAMES (8),
    .CLEAN_FRAMES(24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exec        (exec),
    .selected    (selected),
    .exec_status (exec_status),
    .anim_active (anim_active),
    .anim_action (anim_action),
    .frame_index (frame_index),
    .sprite_addr (sprite_addr),
    .frame_strobe(frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: an animation is described only by its start cycle and action.
  bit       m_active = 1'b0;
  int       m_s      = 0;
  logic [1:0] m_act  = 2'b00;
  bit       m_exec_q = 1'b1;

  int busy_cnt;
  int strobe_cnt;
  int max_frame;
  logic [6:0] last_addr;

  function automatic int frames(input logic [1:0] a);
    case (a)
      2'b01:   return 8;
      2'b10:   return 8;
      2'b11:   return 24;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit fall;
    bit start;
    int k;
    logic       e_status, e_active, e_strobe;
    logic [1:0] e_act;
    logic [4:0] e_frame;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_active = 1'b0;
      m_exec_q = 1'b1;
    end else begin
      fall  = !exec && m_exec_q;
      start = exec && !m_exec_q;
      if (m_active) begin
        if (ABORT_EN && fall) m_active = 1'b0;
        else if (cyc - m_s == frames(m_act) * TICKS) m_active = 1'b0;
      end else if (start && selected != 2'b00) begin
        m_active = 1'b1;
        m_s      = cyc;
        m_act    = selected;
      end
      m_exec_q = exec;
    end
    #1;
    if (m_active) begin
      k        = cyc - m_s;
      e_status = 1'b0;
      e_active = 1'b1;
      e_act    = m_act;
      e_frame  = 5'(k / TICKS);
      e_strobe = (k % TICKS) == 0;
    end else begin
      e_status = 1'b1;
      e_active = 1'b0;
      e_act    = 2'b00;
      e_frame  = 5'd0;
      e_strobe = 1'b0;
    end
    chk("exec_status",  32'(exec_status),  32'(e_status));
    chk("anim_active",  32'(anim_active),  32'(e_active));
    chk("anim_action",  32'(anim_action),  32'(e_act));
    chk("frame_index",  32'(frame_index),  32'(e_frame));
    chk("sprite_addr",  32'(sprite_addr),  32'({e_act, e_frame}));
    chk("frame_strobe", 32'(frame_strobe), 32'(e_strobe));
    if (exec_status === 1'b0) busy_cnt++;
    if (frame_strobe === 1'b1) strobe_cnt++;
    if (anim_active === 1'b1) begin
      last_addr = sprite_addr;
      if (int'(frame_index) > max_frame) max_frame = int'(frame_index);
    end
  endtask

  task automatic clr_stats();
    busy_cnt   = 0;
    strobe_cnt = 0;
    max_frame  = 0;
    last_addr  = 7'd0;
  endtask

  initial begin
    rst      = 1'b0;
    exec     = 1'b1;
    selected = 2'b01;
    clr_stats();

    // 1. reset with exec held high, then release: no start.
    step();
    step();
    chk("reset_status", 32'(exec_status), 32'd1);
    chk("reset_addr",   32'(sprite_addr), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("held_exec_no_start", 32'(anim_active), 32'd0);

    // 2. feed: 8 frames, 32 busy cycles.
    exec = 1'b0;
    step();
    clr_stats();
    exec     = 1'b1;
    selected = 2'b01;
    step();
    chk("feed_first_status", 32'(exec_status),  32'd0);
    chk("feed_first_addr",   32'(sprite_addr),  32'b0100000);
    chk("feed_first_strobe", 32'(frame_strobe), 32'd1);
    for (int i = 0; i < 40; i++) step();
    chk("feed_busy_cycles", 32'(busy_cnt),   32'd32);
    chk("feed_strobes",     32'(strobe_cnt), 32'd8);
    chk("feed_max_frame",   32'(max_frame),  32'd7);

    // 3. clean: 24 frames; mid-run pulses and selection changes are ignored.
    exec = 1'b0;
    step();
    clr_stats();
    exec     = 1'b1;
    selected = 2'b11;
    step();
    for (int i = 0; i < 100; i++) begin
      if (!ABORT_EN && (i % 17 == 5)) exec = ~exec;
      if (i == 30) selected = 2'b01;
      step();
    end
    chk("clean_busy_cycles", 32'(busy_cnt),   32'd96);
    chk("clean_strobes",     32'(strobe_cnt), 32'd24);
    chk("clean_last_addr",   32'(last_addr),  32'b1110111);

    // 4. exec rise with no action selected.
    exec = 1'b0;
    step();
    selected = 2'b00;
    exec     = 1'b1;
    step();
    step();
    chk("none_status", 32'(exec_status), 32'd1);
    chk("none_active", 32'(anim_active), 32'd0);

    // 5. reset during frame 3 of play.
    exec = 1'b0;
    step();
    selected = 2'b10;
    exec     = 1'b1;
    step();
    for (int i = 0; i < 13; i++) step();
    chk("play_frame3", 32'(frame_index), 32'd3);
    rst = 1'b0;
    step();
    chk("midreset_status", 32'(exec_status), 32'd1);
    chk("midreset_frame",  32'(frame_index), 32'd0);
    chk("midreset_action", 32'(anim_action), 32'd0);
    rst  = 1'b1;
    exec = 1'b0;
    step();

    // 6. exec falls during frame 2 of feed.
    clr_stats();
    selected = 2'b01;
    exec     = 1'b1;
    step();
    for (int i = 0; i < 9; i++) step();
    exec = 1'b0;
    step();
    if (ABORT_EN) begin
      chk("abort_status", 32'(exec_status), 32'd1);
      chk("abort_active", 32'(anim_active), 32'd0);
    end else begin
      for (int i = 0; i < 30; i++) step();
      chk("noabort_busy_cycles", 32'(busy_cnt), 32'd32);
    end

    // Random phase against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) exec = ~exec;
      if ($urandom_range(0, 15) == 0) selected = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
